// File: rtl/secuencia_ctrl_if.sv
// rtl/secuencia_ctrl_if.sv - run controller <-> board/detector signal bundle
interface secuencia_ctrl_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N + 1);

  logic          start;
  logic [N-1:0]  pattern;
  logic          z_in;
  logic          w_out;
  logic          det_reset;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic [N-1:0]  match_map;

  modport master (
    output start, pattern, z_in,
    input  w_out, det_reset, busy, done, count, match_map
  );

  modport slave (
    input  start, pattern, z_in,
    output w_out, det_reset, busy, done, count, match_map
  );
endinterface

// File: rtl/secuencia_ctrl.sv
// rtl/secuencia_ctrl.sv - feeds a captured pattern MSB-first to a Mealy detector and records hits
module secuencia_ctrl #(
  parameter int N = 8
) (
  input logic             clk,
  input logic             reset,
  secuencia_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  map_q, map_d;
  logic          det_reset_q, det_reset_d;
  logic          w_out_q, w_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start_edge;
  logic          last_bit;
  logic [IW-1:0] bit_pos;

  always_comb begin
    state_d     = state_q;
    start_d     = bus.start;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    count_d     = count_q;
    map_d       = map_q;
    det_reset_d = det_reset_q;
    w_out_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    start_edge  = bus.start & ~start_q;
    last_bit    = (idx_q == IW'(N - 1));
    bit_pos     = IW'(N - 1) - idx_q;

    // w_out/busy/done are the values for the state being entered, so they are glitch-free flops
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          sreg_d      = bus.pattern;
          count_d     = '0;
          map_d       = '0;
          det_reset_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_CLR;
        end
      end
      S_CLR: begin
        det_reset_d = 1'b0;
        idx_d       = '0;
        busy_d      = 1'b1;
        w_out_d     = sreg_q[N-1];
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        map_d[bit_pos] = bus.z_in;
        count_d        = count_q + CW'(bus.z_in);
        sreg_d         = {sreg_q[N-2:0], 1'b0};
        idx_d          = idx_q + IW'(1);
        if (last_bit) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          w_out_d = sreg_q[N-2];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      sreg_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      map_q       <= '0;
      det_reset_q <= 1'b0;
      w_out_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      sreg_q      <= sreg_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      map_q       <= map_d;
      det_reset_q <= det_reset_d;
      w_out_q     <= w_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.w_out     = w_out_q;
  assign bus.det_reset = det_reset_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;
  assign bus.match_map = map_q;
endmodule

// File: tb/tb_secuencia_ctrl.sv
// tb/tb_secuencia_ctrl.sv - scoreboard bench for secuencia_ctrl with a two-ones Mealy detector model
module tb_secuencia_ctrl;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [N-1:0]  map;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  secuencia_ctrl_if #(.N(N)) bus ();
  secuencia_ctrl #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // detector: S1 after a 1, z = 1 when another 1 arrives in S1
  logic det_s;
  always @(posedge clk or posedge reset) begin
    if (reset)              det_s <= 1'b0;
    else if (bus.det_reset) det_s <= 1'b0;
    else                    det_s <= bus.w_out;
  end
  assign bus.z_in = det_s & bus.w_out;

  exp_t exp_q[$];
  logic w_exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t expect_of(input logic [N-1:0] p);
    exp_t e;
    e.cnt = '0;
    e.map = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (p[k] && p[k+1]) begin
        e.map[k] = 1'b1;
        e.cnt    = e.cnt + 1'b1;
      end
    end
    return e;
  endfunction

  task automatic start_run(input logic [N-1:0] p);
    exp_q.push_back(expect_of(p));
    for (int k = N - 1; k >= 0; k--) w_exp_q.push_back(p[k]);
    @(posedge clk);
    #1;
    bus.pattern = p;
    bus.start   = 1'b1;
  endtask

  task automatic release_start();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic observe(input int cycles, output int dones, output int busy_c, output int detr_c);
    exp_t e;
    logic w;
    dones  = 0;
    busy_c = 0;
    detr_c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.busy) busy_c++;
      if (bus.det_reset) detr_c++;
      checks++;
      if (bus.busy && !bus.det_reset) begin
        if (w_exp_q.size() == 0) begin
          errors++;
          $display("FAIL w_out_seq: w_out=%0b while no bit was expected", bus.w_out);
        end else begin
          w = w_exp_q.pop_front();
          if (bus.w_out !== w) begin
            errors++;
            $display("FAIL w_out_seq: actual %0b expected %0b", bus.w_out, w);
          end
        end
      end else if (bus.w_out !== 1'b0) begin
        errors++;
        $display("FAIL w_out_quiet: actual %0b expected 0", bus.w_out);
      end
      if (bus.done) begin
        dones++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1 with no run pending");
        end else begin
          e = exp_q.pop_front();
          if (bus.count !== e.cnt) begin
            errors++;
            $display("FAIL count: actual %0d expected %0d", bus.count, e.cnt);
          end
          checks++;
          if (bus.match_map !== e.map) begin
            errors++;
            $display("FAIL match_map: actual %b expected %b", bus.match_map, e.map);
          end
          checks++;
          if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: actual %0b expected 0", bus.busy);
          end
        end
      end
    end
  endtask

  task automatic check_run_shape(input string name, input int dones, input int busy_c, input int detr_c);
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL %s_done_pulses: actual %0d expected 1", name, dones);
    end
    checks++;
    if (busy_c !== N + 1) begin
      errors++;
      $display("FAIL %s_busy_cycles: actual %0d expected %0d", name, busy_c, N + 1);
    end
    checks++;
    if (detr_c !== 1) begin
      errors++;
      $display("FAIL %s_det_reset_cycles: actual %0d expected 1", name, detr_c);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({bus.w_out, bus.det_reset, bus.busy, bus.done} !== 4'b0000 ||
        bus.count !== '0 || bus.match_map !== '0) begin
      errors++;
      $display("FAIL %s: w=%0b dr=%0b busy=%0b done=%0b count=%0d map=%b expected all 0",
               name, bus.w_out, bus.det_reset, bus.busy, bus.done, bus.count, bus.match_map);
    end
  endtask

  task automatic test_reset();
    bus.start   = 1'b0;
    bus.pattern = '0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle_after_reset");
  endtask

  task automatic test_pattern(input logic [N-1:0] p, input string name);
    int d, b, r;
    start_run(p);
    release_start();
    observe(12, d, b, r);
    check_run_shape(name, d, b, r);
  endtask

  task automatic test_start_held();
    int d1, b1, r1, d2, b2, r2;
    start_run(8'b0110_1110);
    observe(30, d1, b1, r1);
    bus.start = 1'b0;
    observe(2, d2, b2, r2);
    check_run_shape("held", d1 + d2, b1 + b2, r1 + r2);
    // second start pulse with a new pattern mid-SHIFT must be ignored
    start_run(8'h55);
    release_start();
    observe(4, d1, b1, r1);
    bus.pattern = 8'hFF;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    observe(12, d2, b2, r2);
    check_run_shape("mid_pulse", d1 + d2, b1 + b2, r1 + r2);
  endtask

  task automatic test_reset_mid_run();
    int d, b, r;
    start_run(8'hFF);
    release_start();
    observe(5, d, b, r);
    @(negedge clk);
    checks++;
    if (bus.count !== 3) begin
      errors++;
      $display("FAIL partial_count_idx4: actual %0d expected 3", bus.count);
    end
    reset = 1'b1;
    #1;
    check_quiet("async_reset_mid_run");
    exp_q.delete();
    w_exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    test_pattern(8'hC0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int d, b, r;
    start_run(8'hFF);
    release_start();
    observe(10, d, b, r);
    check_run_shape("b2b_first", d, b, r);
    start_run(8'hC0);
    checks++;
    if (bus.count !== 7 || bus.match_map !== 8'h7F) begin
      errors++;
      $display("FAIL held_results: count=%0d map=%b expected 7 01111111", bus.count, bus.match_map);
    end
    release_start();
    @(negedge clk);
    checks++;
    if (bus.count !== '0 || bus.match_map !== '0 || bus.det_reset !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_at_start: count=%0d map=%b dr=%0b busy=%0b expected 0 0 1 1",
               bus.count, bus.match_map, bus.det_reset, bus.busy);
    end
    observe(10, d, b, r);
    checks++;
    if (d !== 1 || b !== N) begin
      errors++;
      $display("FAIL b2b_second_shape: dones=%0d busy=%0d expected 1 %0d", d, b, N);
    end
  endtask

  initial begin
    test_reset();
    test_pattern(8'b0110_1110, "basic");
    test_pattern(8'hFF, "all_ones");
    test_pattern(8'h55, "alternating");
    test_pattern(8'h00, "all_zeros");
    test_start_held();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0 || w_exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results and %0d bits left", exp_q.size(), w_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
